// File: rtl/walksat_overlord.sv
// Top-level controller of the multi-thread WalkSAT solver: forwards host load
// traffic to the datapath and sequences one-hot flip phases until solved or out of budget.
module walksat_overlord #(
    parameter int          NSAT                      = 3,
    parameter int          NUM_VARIABLES             = 2048,
    parameter int          MAX_CLAUSE_MEMBERSHIP     = 20,
    parameter int          FIFO_DEPTH                = 32,
    parameter int          UNSAT_CLAUSE_BUFFER_DEPTH = 2048,
    parameter int          CONTROLLER_SIGNAL_WIDTH   = 14,
    parameter logic [31:0] MAX_FLIPS                 = 32'h00FF_FFFF,
    parameter int          NUM_THREADS               = 4,
    localparam int VAW          = $clog2(NUM_VARIABLES),
    localparam int LAW          = VAW + 1,
    localparam int CT_WIDTH     = LAW * (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP,
    localparam int UAW          = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH),
    localparam int CLAUSE_WIDTH = NSAT * LAW,
    localparam int TW           = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int PW           = (CONTROLLER_SIGNAL_WIDTH > 1) ? $clog2(CONTROLLER_SIGNAL_WIDTH) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cpu_start,
    input  logic                               load_end,
    input  logic                               att_load_valid,
    input  logic [LAW:0]                       att_load_addr,
    input  logic [VAW+MAX_CLAUSE_MEMBERSHIP-1:0] att_load_data,
    input  logic                               ct_load_valid,
    input  logic [VAW-1:0]                     ct_load_addr,
    input  logic [CT_WIDTH-1:0]                ct_load_data,
    input  logic                               ucb_load_valid,
    input  logic [UAW-1:0]                     ucb_load_addr,
    input  logic [CLAUSE_WIDTH-1:0]            ucb_load_data,
    input  logic [10:0]                        unsat_buffer_count,
    output logic                               cpu_done,
    output logic                               sat_o,
    output logic [TW-1:0]                      thread_sel_o,
    output logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_signal_o,
    output logic                               att_wr_en_o,
    output logic [LAW:0]                       att_wr_addr_o,
    output logic [VAW+MAX_CLAUSE_MEMBERSHIP-1:0] att_wr_data_o,
    output logic                               ct_wr_en_o,
    output logic [VAW-1:0]                     ct_wr_addr_o,
    output logic [CT_WIDTH-1:0]                ct_wr_data_o,
    output logic                               ucb_setup_wr_en_o,
    output logic [UAW-1:0]                     ucb_setup_addr_o,
    output logic [CLAUSE_WIDTH-1:0]            ucb_setup_data_o,
    output logic                               ucb_setup_o,
    output logic [31:0]                        flip_count_o
);

    typedef enum logic [1:0] {LOAD, READY, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase;
    logic [31:0]   flip_inc;
    logic          last_phase;
    logic          last_thread;
    logic          zero_unsat;

    // FIFO_DEPTH sizes datapath storage only; it is carried here for parameter symmetry.
    if (FIFO_DEPTH < 1) begin : g_fifo_depth_invalid
    end

    assign flip_inc    = flip_count_o + 32'd1;
    assign last_phase  = (phase == PW'(CONTROLLER_SIGNAL_WIDTH - 1));
    assign last_thread = (thread_sel_o == TW'(NUM_THREADS - 1));
    assign zero_unsat  = (unsat_buffer_count == '0);

    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // registers update from pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:  if (load_end && last_thread) state_nxt = READY;
            READY: if (cpu_start) state_nxt = (MAX_FLIPS == 32'd0) ? DONE : RUN;
            RUN:   if (last_phase && (zero_unsat || flip_inc == MAX_FLIPS)) state_nxt = DONE;
            DONE:  state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        cpu_done         = (state == DONE);
        ucb_setup_o      = (state == LOAD);
        control_signal_o = '0;
        if (state == RUN) control_signal_o = CONTROLLER_SIGNAL_WIDTH'(1) << phase;
    end

    // Flip sequencing: phase, flip budget, thread rotation and the sat verdict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase        <= '0;
            flip_count_o <= '0;
            thread_sel_o <= '0;
            sat_o        <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (load_end) thread_sel_o <= last_thread ? '0 : thread_sel_o + TW'(1);
                end
                READY: begin
                    if (cpu_start) begin
                        phase        <= '0;
                        flip_count_o <= '0;
                        sat_o        <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_phase) begin
                        flip_count_o <= flip_inc;
                        if (zero_unsat) begin
                            sat_o <= 1'b1;
                        end else if (flip_inc != MAX_FLIPS) begin
                            phase        <= '0;
                            thread_sel_o <= last_thread ? '0 : thread_sel_o + TW'(1);
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Load forwarding: one-cycle registered strobes, accepted only while loading.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            att_wr_en_o       <= 1'b0;
            att_wr_addr_o     <= '0;
            att_wr_data_o     <= '0;
            ct_wr_en_o        <= 1'b0;
            ct_wr_addr_o      <= '0;
            ct_wr_data_o      <= '0;
            ucb_setup_wr_en_o <= 1'b0;
            ucb_setup_addr_o  <= '0;
            ucb_setup_data_o  <= '0;
        end else begin
            att_wr_en_o       <= (state == LOAD) && att_load_valid;
            ct_wr_en_o        <= (state == LOAD) && ct_load_valid;
            ucb_setup_wr_en_o <= (state == LOAD) && ucb_load_valid;
            if (state == LOAD && att_load_valid) begin
                att_wr_addr_o <= att_load_addr;
                att_wr_data_o <= att_load_data;
            end
            if (state == LOAD && ct_load_valid) begin
                ct_wr_addr_o <= ct_load_addr;
                ct_wr_data_o <= ct_load_data;
            end
            if (state == LOAD && ucb_load_valid) begin
                ucb_setup_addr_o <= ucb_load_addr;
                ucb_setup_data_o <= ucb_load_data;
            end
        end
    end

endmodule

// File: tb/tb_walksat_overlord.sv
// Directed bench for walksat_overlord: load forwarding, thread stepping, flip
// budget exhaustion, early zero-unsat exit and asynchronous abort.
module tb_walksat_overlord;

    localparam int CSW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_start = 1'b0;
    logic          load_end = 1'b0;
    logic          att_load_valid = 1'b0;
    logic [12:0]   att_load_addr = '0;
    logic [30:0]   att_load_data = '0;
    logic          ct_load_valid = 1'b0;
    logic [10:0]   ct_load_addr = '0;
    logic [479:0]  ct_load_data = '0;
    logic          ucb_load_valid = 1'b0;
    logic [10:0]   ucb_load_addr = '0;
    logic [35:0]   ucb_load_data = '0;
    logic [10:0]   unsat_buffer_count = 11'd3;

    logic          cpu_done, sat_o, ucb_setup_o;
    logic [1:0]    thread_sel_o;
    logic [CSW-1:0] control_signal_o;
    logic          att_wr_en_o, ct_wr_en_o, ucb_setup_wr_en_o;
    logic [12:0]   att_wr_addr_o;
    logic [30:0]   att_wr_data_o;
    logic [10:0]   ct_wr_addr_o;
    logic [479:0]  ct_wr_data_o;
    logic [10:0]   ucb_setup_addr_o;
    logic [35:0]   ucb_setup_data_o;
    logic [31:0]   flip_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    walksat_overlord #(.MAX_FLIPS(32'd100)) dut (
        .clk(clk), .rst(rst), .cpu_start(cpu_start), .load_end(load_end),
        .att_load_valid(att_load_valid), .att_load_addr(att_load_addr), .att_load_data(att_load_data),
        .ct_load_valid(ct_load_valid), .ct_load_addr(ct_load_addr), .ct_load_data(ct_load_data),
        .ucb_load_valid(ucb_load_valid), .ucb_load_addr(ucb_load_addr), .ucb_load_data(ucb_load_data),
        .unsat_buffer_count(unsat_buffer_count),
        .cpu_done(cpu_done), .sat_o(sat_o), .thread_sel_o(thread_sel_o),
        .control_signal_o(control_signal_o),
        .att_wr_en_o(att_wr_en_o), .att_wr_addr_o(att_wr_addr_o), .att_wr_data_o(att_wr_data_o),
        .ct_wr_en_o(ct_wr_en_o), .ct_wr_addr_o(ct_wr_addr_o), .ct_wr_data_o(ct_wr_data_o),
        .ucb_setup_wr_en_o(ucb_setup_wr_en_o), .ucb_setup_addr_o(ucb_setup_addr_o),
        .ucb_setup_data_o(ucb_setup_data_o), .ucb_setup_o(ucb_setup_o), .flip_count_o(flip_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, well clear of sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},    512'(cpu_done), 512'(0));
        check({tag, "_sat"},     512'(sat_o), 512'(0));
        check({tag, "_thread"},  512'(thread_sel_o), 512'(0));
        check({tag, "_ctrl"},    512'(control_signal_o), 512'(0));
        check({tag, "_flips"},   512'(flip_count_o), 512'(0));
        check({tag, "_wr_en"},   512'({att_wr_en_o, ct_wr_en_o, ucb_setup_wr_en_o}), 512'(0));
        check({tag, "_setup"},   512'(ucb_setup_o), 512'(1));
    endtask

    task automatic load_all_threads(input bit verbose);
        for (int i = 0; i < 4; i++) begin
            load_end = 1'b1;
            tick();
            load_end = 1'b0;
            if (verbose) begin
                check($sformatf("load_end%0d_thread", i), 512'(thread_sel_o), 512'((i + 1) % 4));
                check($sformatf("load_end%0d_setup", i), 512'(ucb_setup_o), 512'(i < 3));
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Runs one solve from READY. zero_at: cycle after which unsat drops to 0;
    // abort_at: cycle at which reset is asserted mid-run (-1 disables either).
    task automatic do_run(input string tag, input int zero_at, input int abort_at,
                          input int exp_cycles, input bit exp_sat,
                          input int exp_flips, input int exp_thread);
        int cyc;
        int done_at;
        unsat_buffer_count = 11'd3;
        cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        cyc = 0;
        done_at = -1;
        check({tag, "_phase0"}, 512'(control_signal_o), 512'(1));
        while (done_at < 0 && cyc < 2000) begin
            if (cyc == zero_at) unsat_buffer_count = 11'd0;
            if (cyc == abort_at) begin
                #2 rst = 1'b0;
                #1 check_idle_outputs({tag, "_abort"});
                tick();
                rst = 1'b1;
                unsat_buffer_count = 11'd3;
                return;
            end
            tick();
            cyc++;
            if (cpu_done) done_at = cyc;
            else if (cyc == 1) check({tag, "_phase1"}, 512'(control_signal_o), 512'(2));
            else if (cyc == 13) check({tag, "_phase13"}, 512'(control_signal_o), 512'(1 << 13));
            else if (cyc == 14) begin
                check({tag, "_flip1_wrap"}, 512'(control_signal_o), 512'(1));
                check({tag, "_flip1_thread"}, 512'(thread_sel_o), 512'(1));
                check({tag, "_flip1_count"}, 512'(flip_count_o), 512'(1));
            end
        end
        check({tag, "_done_cycle"}, 512'(done_at), 512'(exp_cycles));
        check({tag, "_sat"},        512'(sat_o), 512'(exp_sat));
        check({tag, "_flips"},      512'(flip_count_o), 512'(exp_flips));
        check({tag, "_thread"},     512'(thread_sel_o), 512'(exp_thread));
        check({tag, "_ctrl_off"},   512'(control_signal_o), 512'(0));
        unsat_buffer_count = 11'd5;
        cpu_start = 1'b1;
        ct_load_valid = 1'b1;
        repeat (3) tick();
        cpu_start = 1'b0;
        ct_load_valid = 1'b0;
        check({tag, "_hold_done"},   512'(cpu_done), 512'(1));
        check({tag, "_hold_sat"},    512'(sat_o), 512'(exp_sat));
        check({tag, "_hold_flips"},  512'(flip_count_o), 512'(exp_flips));
        check({tag, "_hold_thread"}, 512'(thread_sel_o), 512'(exp_thread));
        check({tag, "_hold_wr"},     512'(ct_wr_en_o), 512'(0));
    endtask

    initial begin
        logic [479:0] ct_x;
        ct_x = {15{32'hA5C3_0F17}};

        reset_dut();
        tick();
        check_idle_outputs("reset");

        // Single CT write: strobe appears one edge later for exactly one cycle.
        ct_load_valid = 1'b1;
        ct_load_addr  = 11'd5;
        ct_load_data  = ct_x;
        @(negedge clk);
        check("ct_wr_before", 512'(ct_wr_en_o), 512'(0));
        tick();
        ct_load_valid = 1'b0;
        ct_load_addr  = 11'd9;
        ct_load_data  = '0;
        check("ct_wr_en",   512'(ct_wr_en_o), 512'(1));
        check("ct_wr_addr", 512'(ct_wr_addr_o), 512'(5));
        check("ct_wr_data", 512'(ct_wr_data_o), 512'(ct_x));
        check("ct_wr_other", 512'({att_wr_en_o, ucb_setup_wr_en_o}), 512'(0));
        tick();
        check("ct_wr_single", 512'(ct_wr_en_o), 512'(0));
        check("ct_addr_hold", 512'(ct_wr_addr_o), 512'(5));

        // UCB write travels with its address and data.
        ucb_load_valid = 1'b1;
        ucb_load_addr  = 11'h7FF;
        ucb_load_data  = 36'h9_8765_4321;
        tick();
        ucb_load_valid = 1'b0;
        check("ucb_wr_en",   512'(ucb_setup_wr_en_o), 512'(1));
        check("ucb_wr_addr", 512'(ucb_setup_addr_o), 512'(11'h7FF));
        check("ucb_wr_data", 512'(ucb_setup_data_o), 512'(36'h9_8765_4321));

        cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        tick();
        check("start_in_load_setup", 512'(ucb_setup_o), 512'(1));
        check("start_in_load_ctrl",  512'(control_signal_o), 512'(0));
        check("start_in_load_done",  512'(cpu_done), 512'(0));

        load_all_threads(1'b1);

        ct_load_valid = 1'b1;
        load_end = 1'b1;
        tick();
        ct_load_valid = 1'b0;
        load_end = 1'b0;
        check("ready_ct_ignored", 512'(ct_wr_en_o), 512'(0));
        tick();
        check("ready_ct_ignored2", 512'(ct_wr_en_o), 512'(0));
        check("ready_thread", 512'(thread_sel_o), 512'(0));
        check("ready_setup",  512'(ucb_setup_o), 512'(0));
        check("ready_ctrl",   512'(control_signal_o), 512'(0));

        // Budget exhaustion: 100 flips x 14 phases; flip 100 runs on thread 3.
        do_run("budget", -1, -1, 1400, 1'b0, 100, 3);

        reset_dut();
        load_all_threads(1'b0);
        do_run("abort", -1, 50, 0, 1'b0, 0, 0);
        tick();
        check("abort_reload_setup", 512'(ucb_setup_o), 512'(1));

        // Zero-unsat throughout flip 7 (thread 2) wins at the 98th edge.
        load_all_threads(1'b0);
        do_run("early", 84, -1, 98, 1'b1, 7, 2);

        reset_dut();
        load_all_threads(1'b0);
        do_run("rerun", -1, -1, 1400, 1'b0, 100, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/walksat_overlord.md
Name: walksat_overlord

Overview:
- Top-level controller of the multi-thread WalkSAT-style solver. Sits between the host (CPU) load interface and the solver datapath.
- Receives clause-table (CT), assignment/truth-table (ATT) and unsat-clause-buffer (UCB) images serially, one thread at a time, and forwards them to the datapath as registered write strobes.
- On cpu_start it sequences flip operations through a one-hot control word. It stops when the datapath reports zero unsatisfied clauses or when MAX_FLIPS flips have completed, then raises cpu_done.

Parameters:
- NSAT, 3, literals per clause.
- NUM_VARIABLES, 2048, variable count. VAW = clog2(NUM_VARIABLES) = 11; LAW = VAW+1 = 12.
- MAX_CLAUSE_MEMBERSHIP, 20, maximum clauses per variable. CT_WIDTH = LAW*(NSAT-1)*MAX_CLAUSE_MEMBERSHIP = 480.
- FIFO_DEPTH, 32, datapath FIFO depth; passed through only, unused here.
- UNSAT_CLAUSE_BUFFER_DEPTH, 2048, UCB entries. UAW = clog2(UNSAT_CLAUSE_BUFFER_DEPTH) = 11. CLAUSE_WIDTH = NSAT*LAW = 36.
- CONTROLLER_SIGNAL_WIDTH, 14, number of one-hot flip phases.
- MAX_FLIPS, 32'h00FF_FFFF, flip budget.
- NUM_THREADS, 4, threads loaded before start.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-low.
- cpu_start, in, 1, start pulse.
- load_end, in, 1, pulse closing the current thread's load.
- att_load_valid, in, 1, ATT write request.
- att_load_addr, in, LAW+1, ATT write address.
- att_load_data, in, VAW+MAX_CLAUSE_MEMBERSHIP, ATT write data.
- ct_load_valid, in, 1, CT write request.
- ct_load_addr, in, VAW, CT write address.
- ct_load_data, in, CT_WIDTH, CT write data.
- ucb_load_valid, in, 1, UCB write request.
- ucb_load_addr, in, UAW, UCB write address.
- ucb_load_data, in, CLAUSE_WIDTH, UCB write data.
- unsat_buffer_count, in, 11, unsat clause count of the selected thread.
- cpu_done, out, 1, solve finished.
- sat_o, out, 1, a zero-unsat state was reached.
- thread_sel_o, out, clog2(NUM_THREADS), thread being loaded or run.
- control_signal_o, out, CONTROLLER_SIGNAL_WIDTH, one-hot flip phase.
- att_wr_en_o, out, 1, forwarded ATT write enable. att_wr_addr_o and att_wr_data_o carry the forwarded ATT address and data.
- ct_wr_en_o, out, 1, forwarded CT write enable. ct_wr_addr_o and ct_wr_data_o carry the forwarded CT address and data.
- ucb_setup_wr_en_o, out, 1, forwarded UCB write enable. ucb_setup_addr_o and ucb_setup_data_o carry the forwarded UCB address and data.
- ucb_setup_o, out, 1, high while in LOAD.
- flip_count_o, out, 32, flips completed.

Behaviour:
- Reset: every output is 0, state = LOAD, thread index = 0, flip counter = 0. Asserting reset at any time, including mid-RUN, aborts everything and returns to these values.

State machine (states LOAD, READY, RUN, DONE):
- LOAD:
  - Each *_load_valid produces the matching *_wr_en_o one cycle later, with address and data registered alongside it (latency 1). Enables not requested are 0.
  - ucb_setup_o = 1. thread_sel_o = current thread index.
  - load_end increments the thread index. A write in the same cycle as load_end still targets the old thread.
  - On the NUM_THREADS-th load_end: go to READY and reset the thread index to 0.
  - cpu_start is ignored in LOAD.
- READY:
  - Load valids and load_end are ignored; no write enables are produced.
  - cpu_start: go to RUN with phase = 0 and flip_count = 0.
  - If MAX_FLIPS == 0: go directly to DONE with sat_o = 0.
- RUN:
  - control_signal_o = 1 << phase. Phase advances by 1 every cycle, from 0 to CONTROLLER_SIGNAL_WIDTH-1.
  - At the last phase:
    - flip_count increments.
    - If unsat_buffer_count == 0: go to DONE with sat_o = 1.
    - Else if the incremented count == MAX_FLIPS: go to DONE with sat_o = 0.
    - Otherwise phase returns to 0 and thread_sel_o advances round-robin, wrapping from NUM_THREADS-1 to 0.
  - When the zero-unsat and budget conditions hit together, the zero-unsat result wins (sat_o = 1).
  - Load inputs and cpu_start are ignored.
- DONE:
  - cpu_done = 1 and control_signal_o = 0.
  - sat_o, flip_count_o and thread_sel_o hold their values until reset.
  - All other inputs are ignored.
- Timing: with cpu_start sampled at edge E0, cpu_done rises at edge E0 + CONTROLLER_SIGNAL_WIDTH*N, where N is the number of flips executed.

Test Plan:
- Reset then idle: all outputs 0, ucb_setup_o = 1, thread_sel_o = 0.
- Load CT address 5 with data X in thread 0: ct_wr_en_o = 1 for exactly one cycle, one cycle later, with addr 5 and data X. Then four load_end pulses: thread_sel_o steps 0 → 1 → 2 → 3, state reaches READY, and ucb_setup_o drops to 0.
- MAX_FLIPS = 100, unsat_buffer_count held at 3, cpu_start pulse: cpu_done rises 1400 cycles after the start edge, with sat_o = 0 and flip_count_o = 100.
- Same setup but unsat_buffer_count forced to 0 during flip 7: cpu_done rises after 98 cycles, sat_o = 1, flip_count_o = 7, thread_sel_o = 2.
- cpu_start pulsed during LOAD and ct_load_valid pulsed during READY: both are ignored; no state change and no write strobe.
- Reset asserted mid-RUN: all outputs return to 0 immediately. A full reload followed by a new run behaves identically to the first run.
